// File: rtl/kiwi_pkg.sv
// kiwi_pkg
//  Shared definitions for the decode issue controller.
//  - RD_NONE / RD_INT / RD_FP : destination register type encodings (3 is treated as none)
//  - state_t                  : issue controller FSM states
//  - src_pending()            : source-operand hazard lookup across both scoreboard banks
package kiwi_pkg;

    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_INT  = 2'd1;
    localparam logic [1:0] RD_FP   = 2'd2;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HALT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Source register types are not known at decode, so a source is considered
    // pending if either bank has the index pending. Integer x0 is hardwired zero.
    function automatic logic src_pending(input logic [31:0] pend_int,
                                         input logic [31:0] pend_fp,
                                         input logic [4:0]  idx);
        return ((idx != 5'd0) && pend_int[idx]) || pend_fp[idx];
    endfunction

endpackage

// File: rtl/sb_bank.sv
// sb_bank
//  32-entry pending-destination scoreboard with one set port and NUM_WB clear ports.
//  Ports:
//   clk, rst_n    clock, async active-low reset
//   i_set         set bit i_set_idx at the next edge
//   i_set_idx     index to set
//   i_clr_valid   per-port clear request
//   i_clr_idx     per-port clear index, 5 bits per port
//   o_bits        registered scoreboard contents
//   o_pend        bits as seen by hazard checks (same-cycle clears removed when WB_BYPASS=1)
module sb_bank
    import kiwi_pkg::*;
#(
    parameter int NUM_WB    = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_set,
    input  logic [4:0]            i_set_idx,
    input  logic [NUM_WB-1:0]     i_clr_valid,
    input  logic [5*NUM_WB-1:0]   i_clr_idx,
    output logic [31:0]           o_bits,
    output logic [31:0]           o_pend
);

    logic [31:0] r_bits;
    logic [31:0] w_clr_mask;
    logic [31:0] w_set_mask;

    always_comb begin
        w_clr_mask = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (i_clr_valid[k]) begin
                w_clr_mask[i_clr_idx[k*5 +: 5]] = 1'b1;
            end
        end
        w_set_mask = '0;
        if (i_set) begin
            w_set_mask[i_set_idx] = 1'b1;
        end
    end

    // A same-edge set beats a clear: the clear belongs to an older op that
    // shared the destination.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bits <= '0;
        end else begin
            r_bits <= (r_bits & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_bits = r_bits;
    assign o_pend = (WB_BYPASS != 0) ? (r_bits & ~w_clr_mask) : r_bits;

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl
//  Issue/hazard controller for the Decoder stage. Tracks pending int/fp destinations,
//  stalls on RAW/WAW hazards and backend backpressure, forwards redirect flushes and
//  sequences end-of-simulation draining with a watchdog.
//  Ports:
//   clk, rst_n                         clock, async active-low reset
//   decoder_valid_i                    Decoder has a valid op
//   rs1/2/3_valid_i, rs1/2/3_i         source operand usage and indices
//   rd_type_i, rd_i                    destination type (0 none, 1 int, 2 fp, 3 none) and index
//   endsim_i                           current op is the end-of-simulation marker
//   issue_ready_i                      backend can accept an op
//   redirect_i                         front-end redirect
//   wb_valid_i, wb_rd_type_i, wb_rd_i  NUM_WB writeback ports
//   stall_decoder_o, flush_decoder_o   Decoder hold / clear
//   issue_valid_o                      op dispatched this cycle
//   sb_empty_o                         no pending destinations
//   endsim_o, endsim_timeout_o         sticky end-of-simulation status
module decode_issue_ctrl
    import kiwi_pkg::*;
#(
    parameter int NUM_WB       = 2,
    parameter int WB_BYPASS    = 1,
    parameter int HALT_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  decoder_valid_i,
    input  logic                  rs1_valid_i,
    input  logic                  rs2_valid_i,
    input  logic                  rs3_valid_i,
    input  logic [4:0]            rs1_i,
    input  logic [4:0]            rs2_i,
    input  logic [4:0]            rs3_i,
    input  logic [1:0]            rd_type_i,
    input  logic [4:0]            rd_i,
    input  logic                  endsim_i,
    input  logic                  issue_ready_i,
    input  logic                  redirect_i,
    input  logic [NUM_WB-1:0]     wb_valid_i,
    input  logic [2*NUM_WB-1:0]   wb_rd_type_i,
    input  logic [5*NUM_WB-1:0]   wb_rd_i,
    output logic                  stall_decoder_o,
    output logic                  flush_decoder_o,
    output logic                  issue_valid_o,
    output logic                  sb_empty_o,
    output logic                  endsim_o,
    output logic                  endsim_timeout_o
);

    localparam int CNT_W = $clog2(HALT_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(HALT_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(HALT_TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_timeout;
    logic             w_timeout_next;

    logic [31:0]       w_int_bits;
    logic [31:0]       w_int_pend;
    logic [31:0]       w_fp_bits;
    logic [31:0]       w_fp_pend;
    logic [NUM_WB-1:0] w_int_clr;
    logic [NUM_WB-1:0] w_fp_clr;
    logic              w_hazard;
    logic              w_run;
    logic              w_issue;
    logic              w_set_int;
    logic              w_set_fp;
    logic              w_sb_empty;

    // Route each writeback port to the bank named by its rd type.
    always_comb begin
        w_int_clr = '0;
        w_fp_clr  = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            w_int_clr[k] = wb_valid_i[k] && (wb_rd_type_i[k*2 +: 2] == RD_INT);
            w_fp_clr[k]  = wb_valid_i[k] && (wb_rd_type_i[k*2 +: 2] == RD_FP);
        end
    end

    assign w_set_int = w_issue && (rd_type_i == RD_INT) && (rd_i != 5'd0);
    assign w_set_fp  = w_issue && (rd_type_i == RD_FP);

    sb_bank #(.NUM_WB(NUM_WB), .WB_BYPASS(WB_BYPASS)) u_sb_int (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set       (w_set_int),
        .i_set_idx   (rd_i),
        .i_clr_valid (w_int_clr),
        .i_clr_idx   (wb_rd_i),
        .o_bits      (w_int_bits),
        .o_pend      (w_int_pend)
    );

    sb_bank #(.NUM_WB(NUM_WB), .WB_BYPASS(WB_BYPASS)) u_sb_fp (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set       (w_set_fp),
        .i_set_idx   (rd_i),
        .i_clr_valid (w_fp_clr),
        .i_clr_idx   (wb_rd_i),
        .o_bits      (w_fp_bits),
        .o_pend      (w_fp_pend)
    );

    // Hazard depends only on decode fields and the scoreboard, never on
    // decoder_valid_i, so the Decoder's valid gating cannot form a loop.
    always_comb begin
        w_hazard = 1'b0;
        if (rs1_valid_i && src_pending(w_int_pend, w_fp_pend, rs1_i)) w_hazard = 1'b1;
        if (rs2_valid_i && src_pending(w_int_pend, w_fp_pend, rs2_i)) w_hazard = 1'b1;
        if (rs3_valid_i && src_pending(w_int_pend, w_fp_pend, rs3_i)) w_hazard = 1'b1;
        if ((rd_type_i == RD_INT) && (rd_i != 5'd0) && w_int_pend[rd_i]) w_hazard = 1'b1;
        if ((rd_type_i == RD_FP) && w_fp_pend[rd_i]) w_hazard = 1'b1;
    end

    assign w_run      = (r_state == RUN);
    assign w_sb_empty = (w_int_bits == '0) && (w_fp_bits == '0);
    assign w_issue    = decoder_valid_i && !endsim_i && w_run && !w_hazard
                        && issue_ready_i && !redirect_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_timeout <= w_timeout_next;
        end
    end

    // Drain sequencing: DONE needs an empty scoreboard with no writeback still
    // landing this cycle. The watchdog only flags; it never forces a transition.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_timeout_next = r_timeout;
        case (r_state)
            RUN: begin
                w_cnt_next = '0;
                if (!redirect_i && decoder_valid_i && endsim_i) begin
                    w_state_next = HALT;
                end
            end
            HALT: begin
                if (redirect_i) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else if (w_sb_empty && (wb_valid_i == '0)) begin
                    w_state_next = DONE;
                end else begin
                    if (r_cnt != TIMEOUT_VAL) begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                    if (r_cnt == TIMEOUT_LAST) begin
                        w_timeout_next = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_next = DONE;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    assign stall_decoder_o  = w_run ? ((w_hazard || !issue_ready_i) && !redirect_i) : 1'b1;
    assign flush_decoder_o  = redirect_i;
    assign issue_valid_o    = w_issue;
    assign sb_empty_o       = w_sb_empty;
    assign endsim_o         = (r_state == DONE);
    assign endsim_timeout_o = r_timeout;

endmodule
